sp_ram_banked: RTL and testbench



---
 rtl/sp_ram_banked.sv | 103 ++++++++++
 tb/tb_sp_ram_banked.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sp_ram_banked.sv
// sp_ram_banked
//   Single-port, byte-addressable, banked SRAM with per-byte write enables
//   and a registered (1-cycle latency) read port. Storage is NUM_BANKS banks
//   of BANK_SIZE 32-bit words; each access enables only the bank selected by
//   the upper address bits.
//
// Ports:
//   clk_i    - clock, all activity on the rising edge
//   rst_i    - synchronous active-high reset (clears read path, not memory)
//   en_i     - access enable / chip select
//   addr_i   - byte address, bits [1:0] ignored
//   wdata_i  - write data
//   we_i     - 1 = write, 0 = read (qualified by en_i)
//   be_i     - byte enables for writes, be_i[k] covers wdata_i[8k+7:8k]
//   rdata_o  - registered read data, holds between reads
module sp_ram_banked #(
    parameter int unsigned NUM_BANKS  = 8,
    parameter int unsigned BANK_SIZE  = 1024,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(NUM_BANKS*BANK_SIZE*4)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
    localparam int unsigned SEL_W     = (BANK_BITS == 0) ? 1 : BANK_BITS;
    localparam int unsigned ROW_BITS  = $clog2(BANK_SIZE);

    logic [SEL_W-1:0]      w_bank;
    logic [SEL_W-1:0]      r_sel;
    logic [ROW_BITS-1:0]   w_row;
    logic                  w_rd;
    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_bank_q [NUM_BANKS];
    logic                  w_unused_addr;

    // Byte offset within a word is irrelevant for word-wide accesses.
    assign w_unused_addr = ^addr_i[1:0];

    assign w_row = addr_i[ROW_BITS+1:2];

    generate
        if (BANK_BITS == 0) begin : g_one_bank
            assign w_bank = '0;
        end else begin : g_multi_bank
            assign w_bank = addr_i[ADDR_WIDTH-1 -: SEL_W];
        end
    endgenerate

    // Reset suppresses any concurrent access.
    assign w_rd = en_i & ~we_i & ~rst_i;
    assign w_wr = en_i &  we_i & ~rst_i;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [BANK_SIZE];
        logic [DATA_WIDTH-1:0] r_q;
        logic                  w_en;

        assign w_en = (w_bank == SEL_W'(b));

        // Memory array has no reset: contents survive rst_i.
        always_ff @(posedge clk_i) begin
            if (w_wr && w_en) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (be_i[k]) begin
                        r_mem[w_row][8*k +: 8] <= wdata_i[8*k +: 8];
                    end
                end
            end
        end

        // Per-bank output register only loads on a read to this bank, so it
        // holds across idles and writes; reset clears every bank's register.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_q <= '0;
            end else if (w_rd && w_en) begin
                r_q <= r_mem[w_row];
            end
        end

        assign w_bank_q[b] = r_q;
    end

    // Bank select captured with the read request steers the output mux.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sel <= '0;
        end else if (w_rd) begin
            r_sel <= w_bank;
        end
    end

    assign rdata_o = w_bank_q[r_sel];

endmodule

// File: tb/tb_sp_ram_banked.sv
module tb_sp_ram_banked;

    logic        clk_i;
    logic        rst_i;
    logic        en_i;
    logic [14:0] addr_i;
    logic [31:0] wdata_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] rdata_o;

    int unsigned n_pass;
    int unsigned n_total;

    sp_ram_banked #(
        .NUM_BANKS (8),
        .BANK_SIZE (1024),
        .DATA_WIDTH(32),
        .ADDR_WIDTH(15)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .we_i   (we_i),
        .be_i   (be_i),
        .rdata_o(rdata_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        en_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
        tick();
    endtask

    task automatic wr(input logic [14:0] a, input logic [31:0] d, input logic [3:0] be);
        en_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; be_i = be;
        tick();
        en_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic rd(input logic [14:0] a);
        en_i = 1'b1; we_i = 1'b0; addr_i = a; be_i = 4'h0;
        tick();
        en_i = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst_i = 1'b1; en_i = 1'b0; we_i = 1'b0;
        addr_i = '0; wdata_i = '0; be_i = 4'h0;
        tick();
        tick();
        check("reset_rdata", rdata_o, 32'h0000_0000);
        rst_i = 1'b0;

        // Full-word write/read with 1-cycle latency
        wr(15'h0004, 32'hDEAD_BEEF, 4'hF);
        check("write_holds_rdata", rdata_o, 32'h0000_0000);
        rd(15'h0004);
        check("full_word_read", rdata_o, 32'hDEAD_BEEF);

        // Hold across idles and an unrelated write
        idle();
        check("hold_idle1", rdata_o, 32'hDEAD_BEEF);
        idle();
        check("hold_idle2", rdata_o, 32'hDEAD_BEEF);
        idle();
        check("hold_idle3", rdata_o, 32'hDEAD_BEEF);
        wr(15'h0200, 32'h1234_5678, 4'hF);
        check("hold_write", rdata_o, 32'hDEAD_BEEF);

        // Byte enables, read immediately after write (merge)
        wr(15'h0100, 32'h1122_3344, 4'hF);
        wr(15'h0100, 32'hAABB_CCDD, 4'h5);
        rd(15'h0100);
        check("byte_enable_merge", rdata_o, 32'h11BB_33DD);
        wr(15'h0100, 32'hFFFF_FFFF, 4'h0);
        rd(15'h0100);
        check("be_zero_noop", rdata_o, 32'h11BB_33DD);
        wr(15'h0100, 32'h0000_EE00, 4'h2);
        rd(15'h0100);
        check("single_byte_write", rdata_o, 32'h11BB_EEDD);

        // Bank crossing, back-to-back reads
        wr(15'h0FFC, 32'hA5A5_A5A5, 4'hF);
        wr(15'h1000, 32'h5A5A_5A5A, 4'hF);
        en_i = 1'b1; we_i = 1'b0; addr_i = 15'h0FFC;
        tick();
        check("bank0_last", rdata_o, 32'hA5A5_A5A5);
        addr_i = 15'h1000;
        tick();
        check("bank1_first", rdata_o, 32'h5A5A_5A5A);
        addr_i = 15'h0200;
        tick();
        check("bank0_after_bank1", rdata_o, 32'h1234_5678);
        en_i = 1'b0;
        idle();
        check("bank_sel_hold", rdata_o, 32'h1234_5678);

        // Extremes and aliasing of addr[1:0]
        wr(15'h7FFC, 32'h0000_FFFF, 4'hF);
        rd(15'h7FFC);
        check("top_word", rdata_o, 32'h0000_FFFF);
        rd(15'h0000);
        rd(15'h7FFF);
        check("top_word_alias", rdata_o, 32'h0000_FFFF);
        rd(15'h0006);
        check("alias_low_bits", rdata_o, 32'hDEAD_BEEF);

        // Reset two cycles after a read of a nonzero word, with a write attempt
        rd(15'h0004);
        check("pre_reset_read", rdata_o, 32'hDEAD_BEEF);
        idle();
        rst_i = 1'b1; en_i = 1'b1; we_i = 1'b1;
        addr_i = 15'h0004; wdata_i = 32'h0BAD_0BAD; be_i = 4'hF;
        tick();
        check("reset_clears_rdata", rdata_o, 32'h0000_0000);
        rst_i = 1'b0;
        idle();
        check("post_reset_hold", rdata_o, 32'h0000_0000);
        rd(15'h0004);
        check("reset_write_suppressed", rdata_o, 32'hDEAD_BEEF);

        // Read coincident with reset is discarded
        rst_i = 1'b1; en_i = 1'b1; we_i = 1'b0; addr_i = 15'h0100;
        tick();
        check("reset_read_discard", rdata_o, 32'h0000_0000);
        rst_i = 1'b0;
        idle();
        check("reset_read_discard_hold", rdata_o, 32'h0000_0000);
        rd(15'h1000);
        check("read_after_reset", rdata_o, 32'h5A5A_5A5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
